// File: rtl/bb_master.sv
// bb_master: Blackbone bus initiator. Accepts read/write commands on a
// valid/ready port, queues them, and runs each as a SETUP/ENABLE sequence
// on the per_* bus. Read data comes back on the response port.
//
// Build option: define BB_MASTER_FIFO_EN to queue commands in a
// FIFO_DEPTH-entry FIFO. Without it, a single holding register is used.
// Bus timing and responses are the same in both builds.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | bus parked (per_en=1, per_we=0), waiting for a command
// SETUP   | per_en=0, address/direction/write data presented
// ENABLE  | per_en=1, responder acts at the closing edge
// CAPTURE | bus parked, read data sampled from per_dout at the closing edge
module bb_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] per_addr,
  output logic              per_we,
  output logic              per_en,
  output logic [DATA_W-1:0] per_din,
  input  logic [DATA_W-1:0] per_dout
);

  localparam int CMD_W = 1 + ADDR_W + DATA_W;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bb_master: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_ENABLE  = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              per_en_q, per_en_d;
  logic              per_we_q, per_we_d;
  logic [ADDR_W-1:0] per_addr_q, per_addr_d;
  logic [DATA_W-1:0] per_din_q, per_din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [CMD_W-1:0]  cmd_word;
  logic [CMD_W-1:0]  head;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              avail;
  logic              deq;

  assign cmd_word = {cmd_we, cmd_addr, cmd_wdata};
  assign push     = cmd_valid & cmd_ready;
  // An incoming command on an empty queue goes straight to the bus, which
  // is what lets SETUP start in the cycle right after acceptance.
  assign avail    = push | ~q_empty;
  assign deq      = pop & ~q_empty;
  assign {head_we, head_addr, head_wdata} = head;

`ifdef BB_MASTER_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [CMD_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             store;

  assign q_empty   = (count_q == '0);
  assign cmd_ready = (count_q != FULL_CNT);
  assign store     = push & ~(q_empty & pop);
  assign head      = q_empty ? cmd_word : fifo_q[rd_ptr_q];

  // Queue pointers and occupancy.
  always_ff @(posedge mclk or negedge puc_rst) begin
    if (!puc_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({store, deq})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below count_q.
  always_ff @(posedge mclk) begin
    if (store) fifo_q[wr_ptr_q] <= cmd_word;
  end
`else
  logic             hold_valid_q;
  logic [CMD_W-1:0] hold_q;

  assign q_empty   = ~hold_valid_q;
  assign cmd_ready = ~hold_valid_q;
  assign head      = hold_valid_q ? hold_q : cmd_word;

  // Single holding register, emptied as the FSM enters SETUP.
  always_ff @(posedge mclk or negedge puc_rst) begin
    if (!puc_rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (deq) begin
      hold_valid_q <= 1'b0;
    end else if (push && !pop) begin
      hold_valid_q <= 1'b1;
      hold_q       <= cmd_word;
    end
  end
`endif

  // Next-state and registered bus/response outputs.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    per_en_d    = per_en_q;
    per_we_d    = per_we_q;
    per_addr_d  = per_addr_q;
    per_din_d   = per_din_q;
    rsp_valid_d = 1'b0;
    rsp_we_d    = rsp_we_q;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        per_en_d = 1'b1;
        per_we_d = 1'b0;
        pop      = avail;
      end
      S_SETUP: begin
        state_d  = S_ENABLE;
        per_en_d = 1'b1;
      end
      S_ENABLE: begin
        if (per_we_q) begin
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b1;
          state_d     = S_IDLE;
          per_en_d    = 1'b1;
          per_we_d    = 1'b0;
          pop         = avail;
        end else begin
          state_d  = S_CAPTURE;
          per_en_d = 1'b1;
          per_we_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_we_d    = 1'b0;
        rdata_d     = per_dout;
        state_d     = S_IDLE;
        pop         = avail;
      end
      default: begin
        state_d  = S_IDLE;
        per_en_d = 1'b1;
        per_we_d = 1'b0;
      end
    endcase

    // Launching a command is the same from IDLE, ENABLE and CAPTURE.
    if (pop) begin
      state_d    = S_SETUP;
      per_en_d   = 1'b0;
      per_we_d   = head_we;
      per_addr_d = head_addr;
      per_din_d  = head_we ? head_wdata : '0;
    end
  end

  // State and output registers.
  always_ff @(posedge mclk or negedge puc_rst) begin
    if (!puc_rst) begin
      state_q     <= S_IDLE;
      per_en_q    <= 1'b1;
      per_we_q    <= 1'b0;
      per_addr_q  <= '0;
      per_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      per_en_q    <= per_en_d;
      per_we_q    <= per_we_d;
      per_addr_q  <= per_addr_d;
      per_din_q   <= per_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rdata_q     <= rdata_d;
    end
  end

  assign per_en    = per_en_q;
  assign per_we    = per_we_q;
  assign per_addr  = per_addr_q;
  assign per_din   = per_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  // Write responses read as zero; otherwise the last read data is held.
  assign rsp_rdata = (rsp_valid_q && rsp_we_q) ? '0 : rdata_q;

endmodule
